// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle RV32I control FSM.
package multicycle_pkg;

  // FSM state codes; the numeric values are visible on the debug state port.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_R   = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_ERROR  = 4'd10
  } state_t;

  // Major opcodes (IR[6:0]) handled by this control unit.
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation select.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand select.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BIMM = 2'b11;

  // Every datapath control line driven by the FSM, bundled for one-place defaults.
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Where an instruction goes once it retires: keep running or park in IDLE.
  function automatic state_t retire_state(input logic en);
    return en ? S_FETCH : S_IDLE;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_bus_timer.sv
// Memory-request watchdog: flags a request that has waited TIMEOUT cycles
// without mem_ready. A ready in the expiring cycle still wins.
module bus_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ready,
  output logic expired
);

  logic [15:0] count;

  // Count consecutive unanswered request cycles; any idle or completed cycle restarts it.
  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!req || ready) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign expired = req && !ready && (count == 16'(TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the shared RV32I datapath (R-type, lw, sw, beq).
// Control lines are decoded from the current state; state, instret and the
// sticky trap flags are registered.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [3:0]  state,
  output logic [31:0] instret,
  output logic        illegal,
  output logic        bus_err
);

  state_t state_q;
  ctrl_t  ctrl;
  logic   expired;

  bus_timer #(.TIMEOUT(TIMEOUT)) u_bus_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (ctrl.mem_req),
    .ready   (mem_ready),
    .expired (expired)
  );

  // State sequencing, retire counting and sticky trap flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instret <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            state_q <= S_DECODE;
          end else if (expired) begin
            state_q <= S_ERROR;
            bus_err <= 1'b1;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_R:               state_q <= S_EXEC_R;
            OP_LOAD, OP_STORE:  state_q <= S_ADDR;
            OP_BRANCH:          state_q <= S_BRANCH;
            default: begin
              state_q <= S_ERROR;
              illegal <= 1'b1;
            end
          endcase
        end
        S_EXEC_R: state_q <= S_WB_R;
        S_ADDR:   state_q <= (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (mem_ready) begin
            state_q <= S_WB_MEM;
          end else if (expired) begin
            state_q <= S_ERROR;
            bus_err <= 1'b1;
          end
        end
        S_MEM_WR: begin
          if (mem_ready) begin
            state_q <= retire_state(en);
            instret <= instret + 32'd1;
          end else if (expired) begin
            state_q <= S_ERROR;
            bus_err <= 1'b1;
          end
        end
        S_WB_R, S_WB_MEM, S_BRANCH: begin
          state_q <= retire_state(en);
          instret <= instret + 32'd1;
        end
        S_ERROR: state_q <= S_ERROR;
        default: state_q <= S_ERROR;
      endcase
    end
  end

  // Datapath control decode from the current state (plus mem_ready/zero handshakes).
  // NOTE: ctrl gets a full default first so no path through the case leaves a
  // field unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_BIMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.i_or_d  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.i_or_d  = 1'b1;
      end
      S_WB_R: begin
        ctrl.reg_write = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = 1'b1;
        ctrl.pc_write  = zero;
      end
      default: ctrl = '0;
    endcase
  end

  assign mem_req    = ctrl.mem_req;
  assign mem_we     = ctrl.mem_we;
  assign i_or_d     = ctrl.i_or_d;
  assign ir_write   = ctrl.ir_write;
  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign reg_write  = ctrl.reg_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process pushes the
// hand-computed expected outputs for each cycle; a monitor pops and compares
// them on the falling edge.
module tb_multicycle_ctrl;

  // State codes
  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                         S_ADDR = 4'd4, S_MEM_RD = 4'd5, S_MEM_WR = 4'd6, S_WB_R = 4'd7,
                         S_WB_MEM = 4'd8, S_BRANCH = 4'd9, S_ERROR = 4'd10;

  // Opcodes
  localparam logic [6:0] O_R = 7'b0110011, O_LW = 7'b0000011, O_SW = 7'b0100011,
                         O_BEQ = 7'b1100011, O_ILL = 7'b0010011;

  // Control word: mem_req mem_we i_or_d ir_write pc_write pc_src reg_write
  //               mem_to_reg alu_src_a alu_src_b[1:0] alu_op[1:0]
  localparam logic [12:0] C_NONE       = 13'b0_0_0_0_0_0_0_0_0_00_00;
  localparam logic [12:0] C_FETCH_WAIT = 13'b1_0_0_0_0_0_0_0_0_01_00;
  localparam logic [12:0] C_FETCH_GO   = 13'b1_0_0_1_1_0_0_0_0_01_00;
  localparam logic [12:0] C_DECODE     = 13'b0_0_0_0_0_0_0_0_0_11_00;
  localparam logic [12:0] C_EXEC_R     = 13'b0_0_0_0_0_0_0_0_1_00_10;
  localparam logic [12:0] C_ADDR       = 13'b0_0_0_0_0_0_0_0_1_10_00;
  localparam logic [12:0] C_MEM_RD     = 13'b1_0_1_0_0_0_0_0_0_00_00;
  localparam logic [12:0] C_MEM_WR     = 13'b1_1_1_0_0_0_0_0_0_00_00;
  localparam logic [12:0] C_WB_R       = 13'b0_0_0_0_0_0_1_0_0_00_00;
  localparam logic [12:0] C_WB_MEM     = 13'b0_0_0_0_0_0_1_1_0_00_00;
  localparam logic [12:0] C_BR_TAKEN   = 13'b0_0_0_0_1_1_0_0_1_00_01;
  localparam logic [12:0] C_BR_NOT     = 13'b0_0_0_0_0_1_0_0_1_00_01;

  typedef struct {
    logic [3:0]  st;
    logic [12:0] ctrl;
    logic [31:0] instret;
    logic        ill;
    logic        berr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src;
  logic        reg_write, mem_to_reg, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic [3:0]  state;
  logic [31:0] instret;
  logic        illegal, bus_err;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .state      (state),
    .instret    (instret),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  wire [12:0] act_ctrl = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                          reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus: queue the expected outputs, drive inputs, advance.
  task automatic vec(input logic e, input logic [6:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [12:0] c, input logic [31:0] ir,
                     input logic il, input logic be);
    exp_t x;
    x.st = st; x.ctrl = c; x.instret = ir; x.ill = il; x.berr = be;
    exp_q.push_back(x);
    en = e; opcode = op; zero = z; mem_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse with immediate checks before any clock edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, ".rst_state"},   {28'd0, state}, 32'd0);
    check({tag, ".rst_mem_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, ".rst_ctrl"},    {19'd0, act_ctrl}, 32'd0);
    check({tag, ".rst_instret"}, instret, 32'd0);
    check({tag, ".rst_flags"},   {30'd0, illegal, bus_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare the DUT against the oldest queued expectation each cycle.
  initial begin
    int idx = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        check($sformatf("v%0d.state", idx),   {28'd0, state}, {28'd0, x.st});
        check($sformatf("v%0d.ctrl", idx),    {19'd0, act_ctrl}, {19'd0, x.ctrl});
        check($sformatf("v%0d.instret", idx), instret, x.instret);
        check($sformatf("v%0d.illegal", idx), {31'd0, illegal}, {31'd0, x.ill});
        check($sformatf("v%0d.bus_err", idx), {31'd0, bus_err}, {31'd0, x.berr});
        idx++;
      end
    end
  end

  // Directed stimulus
  initial begin
    rst_n = 1'b0; en = 1'b0; opcode = O_R; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds IDLE even with en and mem_ready high
    vec(1, O_R, 0, 1, S_IDLE, C_NONE, 0, 0, 0);
    vec(1, O_R, 0, 1, S_IDLE, C_NONE, 0, 0, 0);
    rst_n = 1'b1;

    // R-type, zero-wait memory: 0,1,2,3,7 then FETCH
    vec(1, O_R, 0, 1, S_IDLE,   C_NONE,     0, 0, 0);
    vec(1, O_R, 0, 1, S_FETCH,  C_FETCH_GO, 0, 0, 0);
    vec(1, O_R, 0, 1, S_DECODE, C_DECODE,   0, 0, 0);
    vec(1, O_R, 0, 1, S_EXEC_R, C_EXEC_R,   0, 0, 0);
    vec(1, O_R, 0, 1, S_WB_R,   C_WB_R,     0, 0, 0);

    // lw with three wait states in MEM_RD: 8 cycles FETCH to FETCH
    vec(1, O_LW, 0, 1, S_FETCH,  C_FETCH_GO, 1, 0, 0);
    vec(1, O_LW, 0, 1, S_DECODE, C_DECODE,   1, 0, 0);
    vec(1, O_LW, 0, 0, S_ADDR,   C_ADDR,     1, 0, 0);
    for (int i = 0; i < 3; i++) vec(1, O_LW, 0, 0, S_MEM_RD, C_MEM_RD, 1, 0, 0);
    vec(1, O_LW, 0, 1, S_MEM_RD, C_MEM_RD,   1, 0, 0);
    vec(1, O_LW, 0, 0, S_WB_MEM, C_WB_MEM,   1, 0, 0);

    // beq taken, then not taken
    vec(1, O_BEQ, 1, 1, S_FETCH,  C_FETCH_GO, 2, 0, 0);
    vec(1, O_BEQ, 1, 1, S_DECODE, C_DECODE,   2, 0, 0);
    vec(1, O_BEQ, 1, 1, S_BRANCH, C_BR_TAKEN, 2, 0, 0);
    vec(1, O_BEQ, 0, 1, S_FETCH,  C_FETCH_GO, 3, 0, 0);
    vec(1, O_BEQ, 0, 1, S_DECODE, C_DECODE,   3, 0, 0);
    vec(1, O_BEQ, 0, 1, S_BRANCH, C_BR_NOT,   3, 0, 0);

    // sw with en dropped mid-instruction: finishes, then parks in IDLE
    vec(1, O_SW, 0, 1, S_FETCH,  C_FETCH_GO, 4, 0, 0);
    vec(0, O_SW, 0, 1, S_DECODE, C_DECODE,   4, 0, 0);
    vec(0, O_SW, 0, 1, S_ADDR,   C_ADDR,     4, 0, 0);
    vec(0, O_SW, 0, 1, S_MEM_WR, C_MEM_WR,   4, 0, 0);
    vec(0, O_SW, 0, 1, S_IDLE,   C_NONE,     5, 0, 0);
    vec(1, O_ILL, 0, 0, S_IDLE,  C_NONE,     5, 0, 0);

    // FETCH: four wait cycles, ready arrives with count == TIMEOUT -> completes
    for (int i = 0; i < 4; i++) vec(1, O_ILL, 0, 0, S_FETCH, C_FETCH_WAIT, 5, 0, 0);
    vec(1, O_ILL, 0, 1, S_FETCH,  C_FETCH_GO, 5, 0, 0);
    // Illegal opcode traps after DECODE; ERROR is inert for 20 cycles
    vec(1, O_ILL, 0, 1, S_DECODE, C_DECODE,   5, 0, 0);
    for (int i = 0; i < 20; i++) vec(1, O_R, 1, 1, S_ERROR, C_NONE, 5, 1, 0);
    do_reset("illegal");

    // mem_ready stuck low in FETCH: ERROR after five request cycles
    vec(1, O_R, 0, 0, S_IDLE, C_NONE, 0, 0, 0);
    for (int i = 0; i < 5; i++) vec(1, O_R, 0, 0, S_FETCH, C_FETCH_WAIT, 0, 0, 0);
    for (int i = 0; i < 3; i++) vec(1, O_R, 0, 1, S_ERROR, C_NONE, 0, 0, 1);
    do_reset("timeout");

    // Asynchronous reset in the middle of a pending store
    vec(1, O_R,  0, 1, S_IDLE,   C_NONE,     0, 0, 0);
    vec(1, O_R,  0, 1, S_FETCH,  C_FETCH_GO, 0, 0, 0);
    vec(1, O_R,  0, 1, S_DECODE, C_DECODE,   0, 0, 0);
    vec(1, O_R,  0, 1, S_EXEC_R, C_EXEC_R,   0, 0, 0);
    vec(1, O_R,  0, 1, S_WB_R,   C_WB_R,     0, 0, 0);
    vec(1, O_SW, 0, 1, S_FETCH,  C_FETCH_GO, 1, 0, 0);
    vec(1, O_SW, 0, 1, S_DECODE, C_DECODE,   1, 0, 0);
    vec(1, O_SW, 0, 0, S_ADDR,   C_ADDR,     1, 0, 0);
    vec(1, O_SW, 0, 0, S_MEM_WR, C_MEM_WR,   1, 0, 0);
    vec(1, O_SW, 0, 0, S_MEM_WR, C_MEM_WR,   1, 0, 0);
    check("midwr.pre_mem_req", {31'd0, mem_req}, 32'd1);
    do_reset("midwr");
    vec(1, O_R, 0, 1, S_IDLE,  C_NONE,     0, 0, 0);
    vec(1, O_R, 0, 1, S_FETCH, C_FETCH_GO, 0, 0, 0);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
